// File: rtl/filter_win_ctrl_if.sv
// Pixel-stream handshake and window-strobe bundle for filter_win_ctrl.
// iValid is a push strobe with no back-pressure: a pixel is taken on any rising clk edge where
// iValid is high and either a frame is in progress or iSof opens one; there is no ready signal.
interface filter_win_ctrl_if #(
    parameter int CNT_W = 12
);
    logic             iValid;
    logic             iSof;
    logic             oClken;
    logic             oWinValid;
    logic [CNT_W-1:0] oRow;
    logic [CNT_W-1:0] oCol;
    logic             oEol;
    logic             oEof;
    logic             oBusy;
    logic             oErr;

    modport master (
        output iValid, iSof,
        input  oClken, oWinValid, oRow, oCol, oEol, oEof, oBusy, oErr
    );

    modport slave (
        input  iValid, iSof,
        output oClken, oWinValid, oRow, oCol, oEol, oEof, oBusy, oErr
    );
endinterface

// File: rtl/filter_win_ctrl.sv
// Raster-scan controller for a 3x3 filter window: tracks the pixel position, gates the
// line-buffer clock enable and flags when a complete window sits inside the image.
module filter_win_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    filter_win_ctrl_if.slave   win_if,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_R = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, col_q, row_d, col_d;
    logic [CNT_W-1:0] cur_r, cur_c;
    logic             accept, win, eol, eof, err_d;
    logic             s1_win, s1_eol, s1_eof;
    logic [CNT_W-1:0] s1_row, s1_col;

    // iSof restarts the position at (0,0) whatever state we are in, which also covers aborts.
    always_comb begin
        accept  = win_if.iValid && (state_q != IDLE || win_if.iSof);
        cur_r   = win_if.iSof ? '0 : row_q;
        cur_c   = win_if.iSof ? '0 : col_q;
        win     = accept && (cur_r >= TWO) && (cur_c >= TWO);
        eol     = win && (cur_c == LAST_C);
        eof     = eol && (cur_r == LAST_R);
        err_d   = accept && win_if.iSof && (state_q != IDLE);
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (accept) begin
            if (cur_c == LAST_C) begin
                col_d = '0;
                row_d = cur_r + ONE;
            end else begin
                col_d = cur_c + ONE;
                row_d = cur_r;
            end
            if (win_if.iSof) begin
                state_d = FILL;
            end else begin
                case (state_q)
                    FILL: if (cur_r == ONE && cur_c == LAST_C) state_d = RUN;
                    RUN: begin
                        if (cur_r == LAST_R && cur_c == LAST_C) begin
                            state_d = IDLE;
                            row_d   = '0;
                            col_d   = '0;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign win_if.oClken = accept && rst_n;
    assign dbg_state     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            row_q            <= '0;
            col_q            <= '0;
            win_if.oBusy     <= 1'b0;
            win_if.oErr      <= 1'b0;
        end else begin
            state_q          <= state_d;
            row_q            <= row_d;
            col_q            <= col_d;
            win_if.oBusy     <= (state_d != IDLE);
            win_if.oErr      <= err_d;
        end
    end

    // Two-stage strobe pipeline advances every cycle; centres only move when a window is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_win           <= 1'b0;
            s1_eol           <= 1'b0;
            s1_eof           <= 1'b0;
            s1_row           <= '0;
            s1_col           <= '0;
            win_if.oWinValid <= 1'b0;
            win_if.oEol      <= 1'b0;
            win_if.oEof      <= 1'b0;
            win_if.oRow      <= '0;
            win_if.oCol      <= '0;
        end else begin
            s1_win           <= win;
            s1_eol           <= eol;
            s1_eof           <= eof;
            if (win) begin
                s1_row <= cur_r - ONE;
                s1_col <= cur_c - ONE;
            end
            win_if.oWinValid <= s1_win;
            win_if.oEol      <= s1_eol;
            win_if.oEof      <= s1_eof;
            if (s1_win) begin
                win_if.oRow <= s1_row;
                win_if.oCol <= s1_col;
            end
        end
    end
endmodule

// File: tb/tb_filter_win_ctrl.sv
// Directed bench for filter_win_ctrl on a 4x3 image: expected window events are hand-listed
// per frame and compared against what the monitor collects from the outputs.
module tb_filter_win_ctrl;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int CNT_W = 4;
  localparam int EW    = 26;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         cyc;
  int         acc_cyc;
  int         n_checks;
  int         n_fail;
  int         stray;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_q[$];
  logic [15:0]   err_exp_q[$];
  logic [15:0]   err_act_q[$];

  filter_win_ctrl_if #(.CNT_W(CNT_W)) intf ();

  filter_win_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .win_if   (intf),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] ev(input int c, input int r, input int cl, input logic eol,
                                       input logic eof);
    logic [15:0] c16;
    logic [3:0]  r4;
    logic [3:0]  cl4;
    c16 = c[15:0];
    r4  = r[3:0];
    cl4 = cl[3:0];
    return {c16, r4, cl4, eol, eof};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (intf.oWinValid) act_q.push_back(ev(cyc, int'(intf.oRow), int'(intf.oCol), intf.oEol, intf.oEof));
      else if (intf.oEol || intf.oEof) stray++;
      if (intf.oErr) err_act_q.push_back(cyc[15:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: present one cycle of inputs, check the combinational clock enable, take the edge
  task automatic px(input logic v, input logic s, input logic exp_ck, input string tag);
    intf.iValid = v;
    intf.iSof   = s;
    #1;
    check(tag, 32'(intf.oClken), 32'(exp_ck));
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    intf.iValid = 1'b0;
    intf.iSof   = 1'b0;
  endtask

  // a clean 12-pixel frame; windows at pixels 11 (2,2) and 12 (2,3)
  task automatic frame12(input bit gaps);
    for (int k = 1; k <= 12; k++) begin
      px(1'b1, k == 1, 1'b1, "clken_px");
      if (k == 1) check("busy_after_sof", 32'(intf.oBusy), 32'd1);
      if (k == 11) exp_q.push_back(ev(acc_cyc + 1, 1, 1, 1'b0, 1'b0));
      if (k == 12) begin
        exp_q.push_back(ev(acc_cyc + 1, 1, 2, 1'b1, 1'b1));
        check("busy_after_last", 32'(intf.oBusy), 32'd0);
        check("state_after_last", 32'(dbg_state), 32'd0);
      end
      if (gaps && k < 12) px(1'b0, 1'b0, 1'b0, "clken_gap");
    end
  endtask

  // scoreboard drain and compare
  task automatic compare_events(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_win_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_win%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
    check({tag, "_err_count"}, 32'(err_act_q.size()), 32'(err_exp_q.size()));
    for (int i = 0; i < err_exp_q.size() && i < err_act_q.size(); i++)
      check($sformatf("%s_err%0d", tag, i), 32'(err_act_q[i]), 32'(err_exp_q[i]));
    check({tag, "_stray_strobe"}, 32'(stray), 32'd0);
    exp_q.delete();
    act_q.delete();
    err_exp_q.delete();
    err_act_q.delete();
    stray = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clken"}, 32'(intf.oClken), 32'd0);
    check({tag, "_winvalid"}, 32'(intf.oWinValid), 32'd0);
    check({tag, "_row"}, 32'(intf.oRow), 32'd0);
    check({tag, "_col"}, 32'(intf.oCol), 32'd0);
    check({tag, "_eol"}, 32'(intf.oEol), 32'd0);
    check({tag, "_eof"}, 32'(intf.oEof), 32'd0);
    check({tag, "_busy"}, 32'(intf.oBusy), 32'd0);
    check({tag, "_err"}, 32'(intf.oErr), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc         = 0;
    n_checks    = 0;
    n_fail      = 0;
    stray       = 0;
    rst_n       = 1'b0;
    intf.iValid = 1'b1;
    intf.iSof   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    intf.iValid = 1'b0;
    intf.iSof   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // consecutive frame
    frame12(1'b0);
    compare_events("frame");

    // iValid toggling every other cycle
    frame12(1'b1);
    compare_events("gapped");

    // stray pixels in IDLE are dropped
    for (int k = 0; k < 5; k++) begin
      px(1'b1, 1'b0, 1'b0, "idle_clken");
      check("idle_busy", 32'(intf.oBusy), 32'd0);
    end
    compare_events("idle");

    // abort with iSof on pixel 7
    for (int k = 1; k <= 6; k++) px(1'b1, k == 1, 1'b1, "abort_clken");
    px(1'b1, 1'b1, 1'b1, "abort_sof_clken");
    err_exp_q.push_back(acc_cyc[15:0]);
    check("abort_state_fill", 32'(dbg_state), 32'd1);
    check("abort_busy", 32'(intf.oBusy), 32'd1);
    for (int k = 2; k <= 12; k++) begin
      px(1'b1, 1'b0, 1'b1, "abort_clken");
      if (k == 11) exp_q.push_back(ev(acc_cyc + 1, 1, 1, 1'b0, 1'b0));
      if (k == 12) exp_q.push_back(ev(acc_cyc + 1, 1, 2, 1'b1, 1'b1));
    end
    compare_events("abort");

    // reset during pixel 10; centres from the previous frame must clear
    for (int k = 1; k <= 9; k++) px(1'b1, k == 1, 1'b1, "rst_clken");
    intf.iValid = 1'b1;
    intf.iSof   = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    intf.iValid = 1'b0;
    intf.iSof   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    px(1'b1, 1'b0, 1'b0, "postreset_nosof_clken");
    check("postreset_busy", 32'(intf.oBusy), 32'd0);
    frame12(1'b0);
    compare_events("postreset");

    // back-to-back frames
    frame12(1'b0);
    frame12(1'b0);
    compare_events("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/filter_win_ctrl.md
FILTER_WIN_CTRL -- requirements
Module: filter_win_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line (>=3).
REQ-002 Parameter IMG_H, default 480, active lines per frame (>=3).
REQ-003 Parameter CNT_W, default 12, width of row/column counters; 2^CNT_W > max(IMG_W, IMG_H).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 iValid  input  1  pixel strobe; one pixel accepted per cycle when high.
REQ-007 iSof  input  1  start of frame; meaningful only with iValid, marks pixel (0,0).
REQ-008 oClken  output  1  combinational line-buffer/window clock-enable = iValid AND pixel accepted.
REQ-009 oWinValid  output  1  3x3 window fully inside image; aligned with datapath output valid.
REQ-010 oRow  output  CNT_W  row of window centre, valid with oWinValid.
REQ-011 oCol  output  CNT_W  column of window centre, valid with oWinValid.
REQ-012 oEol  output  1  last valid window of a line.
REQ-013 oEof  output  1  last valid window of a frame.
REQ-014 oBusy  output  1  frame in progress (state FILL or RUN).
REQ-015 oErr  output  1  one-cycle pulse: frame aborted by early iSof.

Function
REQ-016 FSM states IDLE, FILL, RUN; reset state IDLE.
REQ-017 Pixel accepted = iValid AND (state != IDLE OR iSof).
REQ-018 IDLE: iValid without iSof is dropped, oClken low, counters unchanged.
REQ-019 IDLE + iValid + iSof: pixel (0,0) accepted; col <= 1, row <= 0; next state FILL.
REQ-020 Per accepted pixel: col increments; at col = IMG_W-1 col wraps to 0 and row increments.
REQ-021 FILL -> RUN on acceptance of pixel (1, IMG_W-1).
REQ-022 RUN -> IDLE on acceptance of pixel (IMG_H-1, IMG_W-1); row, col cleared to 0.
REQ-023 iValid + iSof in FILL or RUN: current frame aborted, oErr pulses next cycle, pixel treated as (0,0), state FILL.
REQ-024 iValid low: counters, state hold; no output strobes generated.
REQ-025 Window qualifier for accepted pixel (r,c): win = (r>=2) AND (c>=2); centre = (r-1, c-1).
REQ-026 eol = win AND c = IMG_W-1; eof = eol AND r = IMG_H-1.
REQ-027 win, eol, eof, centre coordinates pass a 2-stage pipeline clocked every cycle; stage advance independent of iValid; oWinValid/oEol/oEof high exactly 2 cycles after the accepting edge, for one cycle.
REQ-028 Pipeline stage 1 loads 0 for win/eol/eof on cycles with no accepted pixel.
REQ-029 oRow/oCol hold last loaded centre when oWinValid low.
REQ-030 oBusy registered, high from cycle after (0,0) acceptance until cycle after final pixel acceptance.
REQ-031 Windows per frame = (IMG_W-2)*(IMG_H-2); no window on an aborted frame's tail after abort point beyond those already in the pipeline.
REQ-032 Aborting iSof does not flush the pipeline; in-flight strobes still emerge.

Reset
REQ-033 rst_n low: state IDLE; row, col, pipeline, oWinValid, oRow, oCol, oEol, oEof, oBusy, oErr all 0, immediately and asynchronously.
REQ-034 Reset mid-frame discards frame; first pixel after release requires iSof.
REQ-035 oClken during reset = 0.

Verification (IMG_W=4, IMG_H=3, CNT_W=4)
REQ-036 12 consecutive valid pixels, iSof on first -> oWinValid high 2 cycles after pixels 11 and 12; centres (1,1),(1,2); oEol on both? no -> oEol, oEof on second only; oBusy low after.
REQ-037 Same frame with iValid toggling every other cycle -> same 2 windows, each 2 cycles after its accepting edge; counters hold on gaps.
REQ-038 iValid without iSof in IDLE for 5 cycles -> oClken 0, oBusy 0, no windows.
REQ-039 iSof re-asserted at pixel 7 -> oErr pulse 1 cycle later; following 12 pixels yield exactly 2 windows at (1,1),(1,2).
REQ-040 rst_n pulsed low at pixel 10 -> all outputs 0 immediately; next frame with iSof behaves per REQ-036.
REQ-041 Two back-to-back frames, iSof on cycle after last pixel -> 4 windows total, oEof twice, no oErr.
